// File: rtl/fabric_merge_pkg.sv
// Shared fabric error codes and helpers for the N-to-1 merge and its buffer.
// Codes are numbered so that a lower value always wins when several fire at once.
package fabric_merge_pkg;

  localparam logic [15:0] FABRIC_OK                  = 16'd0;
  localparam logic [15:0] CFG_MERGE_NO_ENABLED_INPUT = 16'd2;
  localparam logic [15:0] RT_MERGE_DISABLED_INPUT    = 16'd263;

  localparam int MERGE_MIN_INPUTS = 1;
  localparam int MERGE_MAX_INPUTS = 256;

  typedef struct packed {
    logic        vld;
    logic [15:0] code;
  } fabric_err_t;

  // Configuration errors outrank runtime errors (lowest code first).
  function automatic fabric_err_t merge_err_pick(input logic no_enabled,
                                                 input logic disabled_valid);
    fabric_err_t e;
    e.vld  = 1'b0;
    e.code = FABRIC_OK;
    if (no_enabled) begin
      e.vld  = 1'b1;
      e.code = CFG_MERGE_NO_ENABLED_INPUT;
    end else if (disabled_valid) begin
      e.vld  = 1'b1;
      e.code = RT_MERGE_DISABLED_INPUT;
    end
    return e;
  endfunction

endpackage

// File: rtl/fabric_merge_skid2.sv
// Two-entry FIFO used as the merge output buffer (module fabric_skid2).
// Sustains one beat per cycle with simultaneous push and pop; head is raw storage.
module fabric_skid2
  import fabric_merge_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push & (count_q != 2'd2);
    do_pop   = pop & (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fabric_merge.sv
// Round-robin N-to-1 streaming merge with a 2-entry output buffer and a
// report-only sticky error latch.
module fabric_merge
  import fabric_merge_pkg::*;
#(
  parameter  int NUM_INPUTS    = 4,
  parameter  int DATA_WIDTH    = 32,
  parameter  int TAG_WIDTH     = 0,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_INPUTS-1:0]                    in_valid,
  output logic [NUM_INPUTS-1:0]                    in_ready,
  input  logic [NUM_INPUTS-1:0][PAYLOAD_WIDTH-1:0] in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [PAYLOAD_WIDTH-1:0]                 out_data,
  input  logic [NUM_INPUTS-1:0]                    cfg_in_enable,
  output logic                                     error_valid,
  output logic [15:0]                              error_code
);

  localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_INPUTS - 1);

  if (NUM_INPUTS < MERGE_MIN_INPUTS || NUM_INPUTS > MERGE_MAX_INPUTS) begin : g_port_limit
    $fatal(1, "CPL_MERGE_PORT_LIMIT: NUM_INPUTS=%0d outside 1..256", NUM_INPUTS);
  end

  logic [NUM_INPUTS-1:0]    elig;
  logic [NUM_INPUTS-1:0]    grant;
  logic                     found;
  logic [PTR_W-1:0]         winner;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]               count;
  logic                     not_full;
  logic                     push;
  logic                     pop;
  logic [PAYLOAD_WIDTH-1:0] head_data;
  logic [PAYLOAD_WIDTH-1:0] push_data;
  fabric_err_t              err_det;
  logic                     error_valid_q, error_valid_d;
  logic [15:0]              error_code_q, error_code_d;
  int                       scan;
  logic [PTR_W-1:0]         scan_idx;

  assign elig = in_valid & cfg_in_enable;

  // Scan upward from rr_ptr with wraparound; grant is forced off while in reset.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    winner   = '0;
    scan     = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_INPUTS) scan = scan - NUM_INPUTS;
      scan_idx = PTR_W'(scan);
      if (!found && elig[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        winner          = scan_idx;
      end
    end
    if (!rst_n) begin
      grant = '0;
      found = 1'b0;
    end
  end

  // count is registered, so ready never depends on out_ready combinationally.
  assign not_full  = (count != 2'd2);
  assign in_ready  = grant & {NUM_INPUTS{not_full}};
  assign push      = found & not_full;
  assign push_data = in_data[winner];
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? head_data : '0;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  fabric_skid2 #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .count    (count),
    .head_data(head_data)
  );

  assign err_det = merge_err_pick(cfg_in_enable == '0, |(in_valid & ~cfg_in_enable));

  // First error wins; the latch never blocks traffic.
  always_comb begin
    error_valid_d = error_valid_q;
    error_code_d  = error_code_q;
    if (!error_valid_q && err_det.vld) begin
      error_valid_d = 1'b1;
      error_code_d  = err_det.code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_valid_q <= 1'b0;
      error_code_q  <= FABRIC_OK;
    end else begin
      error_valid_q <= error_valid_d;
      error_code_q  <= error_code_d;
    end
  end

  assign error_valid = error_valid_q;
  assign error_code  = error_code_q;

endmodule

// File: tb/tb_fabric_merge.sv
// Directed bench for fabric_merge: handshake, fairness, backpressure,
// error latch priority/stickiness and asynchronous reset mid-stream.
module tb_fabric_merge;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N-1:0][DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [N-1:0]      cfg_in_enable;
  logic              error_valid;
  logic [15:0]       error_code;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  fabric_merge #(
    .NUM_INPUTS(N),
    .DATA_WIDTH(DW),
    .TAG_WIDTH (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .cfg_in_enable(cfg_in_enable),
    .error_valid  (error_valid),
    .error_code   (error_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) in_data[i] = base + 8'(i);
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = '1;
    cfg_in_enable = '1;
    out_ready     = 1'b1;
    set_data(8'hC0);

    // Reset state: valids present but grant masked
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_error_valid", error_valid, 0);
    chk("rst_error_code", error_code, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single input: input 2 sends A5
    in_valid   = 4'b0100;
    in_data[2] = 8'hA5;
    #1 chk("t1_in_ready", in_ready, 4'b0100);
    next_cyc();
    in_valid = '0;
    #1;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 8'hA5);
    chk("t1_no_error", error_valid, 0);
    next_cyc();
    chk("t1_drained", out_valid, 0);
    set_data(8'hC0);

    // Fairness: all valid, full rate
    apply_reset();
    in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_in_ready", in_ready, 32'(1 << (k % 4)));
      if (k > 0) begin
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 32'(8'hC0 + 8'((k - 1) % 4)));
      end
      next_cyc();
    end
    in_valid = '0;
    next_cyc();
    next_cyc();

    // Backpressure: 5 stalled cycles
    apply_reset();
    in_valid  = '1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_in_ready", in_ready, (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : 32'd0);
      if (k > 0) begin
        chk("t3_out_valid", out_valid, 1);
        chk("t3_out_data_stable", out_data, 8'hC0);
      end
      next_cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_full_blocks_push", in_ready, 0);
    chk("t3_head", out_data, 8'hC0);
    next_cyc();
    #1;
    chk("t3_grant_after_release", in_ready, 4'b0100);
    chk("t3_second_beat", out_data, 8'hC1);
    next_cyc();
    chk("t3_third_beat", out_data, 8'hC2);
    in_valid = '0;
    next_cyc();
    next_cyc();

    // Disabled input raises valid
    apply_reset();
    cfg_in_enable = 4'b1011;
    in_valid      = 4'b0100;
    #1;
    chk("t4_disabled_ready", in_ready, 0);
    chk("t4_err_not_yet", error_valid, 0);
    next_cyc();
    chk("t4_error_valid", error_valid, 1);
    chk("t4_error_code", error_code, 16'd263);
    in_valid = 4'b0101;
    #1 chk("t4_other_ready", in_ready, 4'b0001);
    next_cyc();
    chk("t4_traffic_valid", out_valid, 1);
    chk("t4_traffic_data", out_data, 8'hC0);
    chk("t4_code_held", error_code, 16'd263);
    in_valid = '0;
    next_cyc();
    next_cyc();

    // Error priority and stickiness
    apply_reset();
    cfg_in_enable = '0;
    in_valid      = 4'b0001;
    #1 chk("t5_no_ready", in_ready, 0);
    next_cyc();
    chk("t5_error_valid", error_valid, 1);
    chk("t5_error_prio", error_code, 16'd2);
    cfg_in_enable = 4'b1011;
    in_valid      = 4'b0100;
    next_cyc();
    chk("t5_sticky", error_code, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_err_valid", error_valid, 0);
    chk("t5_rst_err_code", error_code, 0);
    in_valid      = '0;
    cfg_in_enable = '1;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream with a full buffer
    apply_reset();
    in_valid  = '1;
    out_ready = 1'b0;
    next_cyc();
    next_cyc();
    #1;
    chk("t6_full_valid", out_valid, 1);
    chk("t6_full_head", out_data, 8'hC0);
    chk("t6_full_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    chk("t6_async_out_data", out_data, 0);
    chk("t6_async_in_ready", in_ready, 0);
    set_data(8'hD0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t6_no_stale", out_valid, 0);
    chk("t6_restart_ptr", in_ready, 4'b0001);
    next_cyc();
    #1;
    chk("t6_fresh_data", out_data, 8'hD0);
    chk("t6_next_grant", in_ready, 4'b0010);
    in_valid = '0;
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
